bf_core: RTL
============

# bf_core

Parametrised Brainfuck execution core, successor to the single-stack `proc` generation. It fetches instructions from a synchronous program memory, operates on a synchronous data memory, and exchanges bytes with the host through valid/ready stdin/stdout channels. It implements all eight opcodes, including forward-skip on `[` with zero data and blocking input on `,`. It sits between the program/data RAMs and the UART bridge in the top level.

## Interface
- `PROG_ADDR_WIDTH`, 8, program address bits
- `DATA_ADDR_WIDTH`, 8, data pointer bits
- `DATA_VALUE_WIDTH`, 8, cell width; wraps modulo 2^width
- `STACK_DEPTH`, 8, loop-stack entries; sets max nesting depth
- `clk`  in  1  clock; all logic on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `en`  in  1  when low, all state and outputs hold
- `prog_addr`  out  PROG_ADDR_WIDTH  instruction address
- `prog_ren`  out  1  program read strobe
- `prog_rval`  in  8  instruction byte, valid the cycle after `prog_ren`
- `data_addr`  out  DATA_ADDR_WIDTH  data pointer
- `data_ren` / `data_wen`  out  1  data read / write strobes
- `data_wval`  out  DATA_VALUE_WIDTH  write value
- `data_rval`  in  DATA_VALUE_WIDTH  read value, valid the cycle after `data_ren`
- `in_data`  in  8 / `in_valid`  in  1 / `in_ready`  out  1  stdin channel
- `out_data`  out  8 / `out_valid`  out  1 / `out_ready`  in  1  stdout channel
- `halted`  out  1  core stopped; sticky until reset
- `exception`  out  1  halt was caused by a fault
- `exc_code`  out  3  fault cause

## Operation
- States: FETCH, DECODE, EXEC, OUT, IN, SKIP, HALT.
- FETCH: assert `prog_ren` at `pc`, then go to DECODE.
- DECODE: set `pc <= pc+1`.
  - `>` / `<`: adjust the pointer, go to FETCH.
  - `+ - . , [ ]`: assert `data_ren`, go to EXEC.
  - NUL: go to HALT with `exception=0`.
  - Any other byte: no-op, go to FETCH.
- EXEC, by opcode:
  - `+` / `-`: write `data_rval±1` (mod 2^DATA_VALUE_WIDTH) with `data_wen`.
  - `.`: drive `out_data` and `out_valid`, go to OUT.
  - `,`: go to IN.
  - `[` with nonzero cell: push `pc`. If the stack is full, fault (code 3).
  - `[` with zero cell: depth counter := 1, go to SKIP.
  - `]` with nonzero cell: `pc <=` top of stack; no pop.
  - `]` with zero cell: pop. If the stack is empty, fault (code 4).
- OUT: hold `out_valid` and `out_data` until `out_ready` is high, then go to FETCH.
- IN: hold `in_ready` until `in_valid` is high, then write `in_data` with `data_wen` and go to FETCH.
- SKIP: fetch and decode instructions without executing them.
  - `[` increments depth; `]` decrements it.
  - When depth reaches 0, go to FETCH.
  - NUL during SKIP faults (code 5).
- Fault codes:
  - 1: pointer underflow
  - 2: pointer overflow
  - 3: stack overflow
  - 4: stack underflow
  - 5: unmatched `[`
  - 6: `pc` increment past the maximum address
- Any fault moves to HALT and sets `halted=1`, `exception=1`, `exc_code`. Memory is not modified on the faulting instruction.
- HALT: all strobes low. Only `reset` leaves HALT.

## Timing
- Reset values:
  - All outputs 0.
  - `pc`, pointer, stack index and depth counter all 0.
  - State FETCH, entered on the first enabled edge after `reset` deasserts.
- Latency with `en` high throughout:
  - `>`, `<`, other bytes: 2 cycles.
  - `+`, `-`, `[`, `]`: 3 cycles.
  - `.`: 3 cycles plus the wait for `out_ready`.
  - `,`: 3 cycles plus the wait for `in_valid`.
  - SKIP: 2 cycles per scanned instruction.
- Handshakes:
  - A stdout transfer completes on a cycle with `out_valid & out_ready`.
  - A stdin transfer completes on a cycle with `in_valid & in_ready`.
  - `out_valid` never drops before its transfer completes.
- `reset` mid-operation: outputs clear immediately (asynchronously). Any pending handshake is abandoned.
- `en` low: all registers and outputs, including strobes, freeze.

## Configuration
- `BF_CELL_WRAP_EN` defined: the data pointer wraps modulo 2^DATA_ADDR_WIDTH; fault codes 1 and 2 never occur.
- `BF_CELL_WRAP_EN` undefined: `<` at pointer 0 faults with code 1; `>` at the maximum pointer faults with code 2.

## Structure
- Package `bf_pkg` holds:
  - Opcode byte constants.
  - The state enum.
  - The `exc_code` constants.
- Sub-module `bf_loop_stack`: parametrised LIFO with ports push, pop, top, full and empty.
- The core FSM, pointer and `pc` live in `bf_core`.

## Test plan
- Program `+++.` followed by NUL → `out_data=3`, one transfer, `halted=1`, `exception=0`.
- Program `,+.` with `in_data=0x41` delayed 5 cycles → `out_data=0x42`; `in_ready` held through the wait.
- Program `[+.]` followed by NUL, cell 0 → SKIP runs, no output, clean halt with `data_wen` never asserted.
- Program `++[->+<]>.` → `out_data=2`; the stack returns to empty.
- Program `<` at pointer 0 → with `BF_CELL_WRAP_EN` undefined: `exc_code=1`; with it defined: pointer becomes 255, no fault.
- `STACK_DEPTH` = 2, program `+[[[` → `exc_code=3`. Separately, `out_ready` held low for 10 cycles on `.` → `out_valid` stays high and stable.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared opcode bytes, FSM state encoding and fault codes for the bf_core execution core.

package bf_pkg;

    localparam logic [7:0] OpNul   = 8'h00;
    localparam logic [7:0] OpRight = 8'h3E;  // >
    localparam logic [7:0] OpLeft  = 8'h3C;  // <
    localparam logic [7:0] OpInc   = 8'h2B;  // +
    localparam logic [7:0] OpDec   = 8'h2D;  // -
    localparam logic [7:0] OpOut   = 8'h2E;  // .
    localparam logic [7:0] OpIn    = 8'h2C;  // ,
    localparam logic [7:0] OpOpen  = 8'h5B;  // [
    localparam logic [7:0] OpClose = 8'h5D;  // ]

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StOut,
        StIn,
        StSkip,
        StHalt
    } state_e;

    localparam logic [2:0] ExcNone       = 3'd0;
    localparam logic [2:0] ExcPtrUnder   = 3'd1;
    localparam logic [2:0] ExcPtrOver    = 3'd2;
    localparam logic [2:0] ExcStackOver  = 3'd3;
    localparam logic [2:0] ExcStackUnder = 3'd4;
    localparam logic [2:0] ExcUnmatched  = 3'd5;
    localparam logic [2:0] ExcPcOver     = 3'd6;

endpackage

// File: rtl/bf_core_if.sv
// Memory and stdin/stdout bundle of bf_core; master is the core, slave is the RAM/UART side.

interface bf_core_if #(
    parameter int unsigned PROG_ADDR_WIDTH  = 8,
    parameter int unsigned DATA_ADDR_WIDTH  = 8,
    parameter int unsigned DATA_VALUE_WIDTH = 8
);
    logic [PROG_ADDR_WIDTH-1:0]  prog_addr;
    logic                        prog_ren;
    logic [7:0]                  prog_rval;
    logic [DATA_ADDR_WIDTH-1:0]  data_addr;
    logic                        data_ren;
    logic                        data_wen;
    logic [DATA_VALUE_WIDTH-1:0] data_wval;
    logic [DATA_VALUE_WIDTH-1:0] data_rval;
    logic [7:0]                  in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [7:0]                  out_data;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output prog_addr, prog_ren, input prog_rval,
        output data_addr, data_ren, data_wen, data_wval, input data_rval,
        input in_data, in_valid, output in_ready,
        output out_data, out_valid, input out_ready
    );

    modport slave (
        input prog_addr, prog_ren, output prog_rval,
        input data_addr, data_ren, data_wen, data_wval, output data_rval,
        output in_data, in_valid, input in_ready,
        input out_data, out_valid, output out_ready
    );
endinterface

// File: rtl/bf_loop_stack.sv
// LIFO of loop return addresses; push/pop are ignored when full/empty respectively.

module bf_loop_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int unsigned CntWidth = $clog2(DEPTH + 1);
    localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CntWidth-1:0] count_q, count_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [IdxWidth-1:0] top_idx;

    assign full    = (count_q == CntWidth'(DEPTH));
    assign empty   = (count_q == '0);
    assign top_idx = IdxWidth'(count_q - CntWidth'(1));
    assign top     = empty ? '0 : mem_q[top_idx];

    always_comb begin
        count_d = count_q;
        if (push && !full) begin
            count_d = count_q + CntWidth'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[IdxWidth'(count_q)] <= push_data;
        end
    end
endmodule

// File: rtl/bf_core.sv
// Brainfuck execution core: FSM, pc and data pointer. Define BF_CELL_WRAP_EN to make the
// data pointer wrap instead of faulting at either end.

module bf_core import bf_pkg::*; #(
    parameter int unsigned PROG_ADDR_WIDTH  = 8,
    parameter int unsigned DATA_ADDR_WIDTH  = 8,
    parameter int unsigned DATA_VALUE_WIDTH = 8,
    parameter int unsigned STACK_DEPTH      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    bf_core_if.master         bus,
    output logic              halted,
    output logic              exception,
    output logic [2:0]        exc_code
);
    state_e                      state_q, state_d;
    logic [PROG_ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [DATA_ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [7:0]                  op_q, op_d;
    logic [PROG_ADDR_WIDTH-1:0]  depth_q, depth_d;
    logic                        skip_phase_q, skip_phase_d;
    logic [7:0]                  out_data_q, out_data_d;
    logic                        exception_q, exception_d;
    logic [2:0]                  exc_code_q, exc_code_d;

    logic                        prog_ren, data_ren, data_wen, in_ready;
    logic [DATA_VALUE_WIDTH-1:0] data_wval;
    logic                        push, pop, stack_full, stack_empty;
    logic [PROG_ADDR_WIDTH-1:0]  stack_top;
    logic                        pc_max, cell_zero;

    assign pc_max    = (pc_q == '1);
    assign cell_zero = (bus.data_rval == '0);

    bf_loop_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PROG_ADDR_WIDTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push && en),
        .pop       (pop && en),
        .push_data (pc_q),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ptr_d        = ptr_q;
        op_d         = op_q;
        depth_d      = depth_q;
        skip_phase_d = skip_phase_q;
        out_data_d   = out_data_q;
        exception_d  = exception_q;
        exc_code_d   = exc_code_q;
        prog_ren     = 1'b0;
        data_ren     = 1'b0;
        data_wen     = 1'b0;
        data_wval    = '0;
        in_ready     = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;

        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                prog_ren = 1'b1;
                state_d  = StDecode;
            end
            StDecode: begin
                op_d = bus.prog_rval;
                if (bus.prog_rval == OpNul) begin
                    state_d = StHalt;
                end else if (pc_max) begin
                    state_d     = StHalt;
                    exception_d = 1'b1;
                    exc_code_d  = ExcPcOver;
                end else begin
                    pc_d    = pc_q + PROG_ADDR_WIDTH'(1);
                    state_d = StFetch;
                    case (bus.prog_rval)
                        OpRight: begin
`ifdef BF_CELL_WRAP_EN
                            ptr_d = ptr_q + DATA_ADDR_WIDTH'(1);
`else
                            if (ptr_q == '1) begin
                                pc_d        = pc_q;
                                state_d     = StHalt;
                                exception_d = 1'b1;
                                exc_code_d  = ExcPtrOver;
                            end else begin
                                ptr_d = ptr_q + DATA_ADDR_WIDTH'(1);
                            end
`endif
                        end
                        OpLeft: begin
`ifdef BF_CELL_WRAP_EN
                            ptr_d = ptr_q - DATA_ADDR_WIDTH'(1);
`else
                            if (ptr_q == '0) begin
                                pc_d        = pc_q;
                                state_d     = StHalt;
                                exception_d = 1'b1;
                                exc_code_d  = ExcPtrUnder;
                            end else begin
                                ptr_d = ptr_q - DATA_ADDR_WIDTH'(1);
                            end
`endif
                        end
                        OpInc, OpDec, OpOut, OpIn, OpOpen, OpClose: begin
                            data_ren = 1'b1;
                            state_d  = StExec;
                        end
                        default: ;
                    endcase
                end
            end
            StExec: begin
                state_d = StFetch;
                case (op_q)
                    OpInc: begin
                        data_wen  = 1'b1;
                        data_wval = bus.data_rval + DATA_VALUE_WIDTH'(1);
                    end
                    OpDec: begin
                        data_wen  = 1'b1;
                        data_wval = bus.data_rval - DATA_VALUE_WIDTH'(1);
                    end
                    OpOut: begin
                        out_data_d = 8'(bus.data_rval);
                        state_d    = StOut;
                    end
                    OpIn: state_d = StIn;
                    OpOpen: begin
                        if (cell_zero) begin
                            depth_d      = PROG_ADDR_WIDTH'(1);
                            skip_phase_d = 1'b0;
                            state_d      = StSkip;
                        end else if (stack_full) begin
                            state_d     = StHalt;
                            exception_d = 1'b1;
                            exc_code_d  = ExcStackOver;
                        end else begin
                            push = 1'b1;
                        end
                    end
                    OpClose: begin
                        // A ']' with no open loop is a fault whatever the cell holds.
                        if (stack_empty) begin
                            state_d     = StHalt;
                            exception_d = 1'b1;
                            exc_code_d  = ExcStackUnder;
                        end else if (cell_zero) begin
                            pop = 1'b1;
                        end else begin
                            pc_d = stack_top;
                        end
                    end
                    default: ;
                endcase
            end
            StOut: begin
                if (bus.out_ready) state_d = StFetch;
            end
            StIn: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    data_wen  = 1'b1;
                    data_wval = DATA_VALUE_WIDTH'(bus.in_data);
                    state_d   = StFetch;
                end
            end
            StSkip: begin
                // Phase 0 fetches, phase 1 inspects the fetched byte.
                if (!skip_phase_q) begin
                    prog_ren     = 1'b1;
                    skip_phase_d = 1'b1;
                end else begin
                    skip_phase_d = 1'b0;
                    if (bus.prog_rval == OpNul) begin
                        state_d     = StHalt;
                        exception_d = 1'b1;
                        exc_code_d  = ExcUnmatched;
                    end else if (pc_max) begin
                        state_d     = StHalt;
                        exception_d = 1'b1;
                        exc_code_d  = ExcPcOver;
                    end else begin
                        pc_d = pc_q + PROG_ADDR_WIDTH'(1);
                        if (bus.prog_rval == OpOpen) begin
                            depth_d = depth_q + PROG_ADDR_WIDTH'(1);
                        end else if (bus.prog_rval == OpClose) begin
                            depth_d = depth_q - PROG_ADDR_WIDTH'(1);
                            if (depth_q == PROG_ADDR_WIDTH'(1)) state_d = StFetch;
                        end
                    end
                end
            end
            StHalt: ;
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            ptr_q        <= '0;
            op_q         <= '0;
            depth_q      <= '0;
            skip_phase_q <= 1'b0;
            out_data_q   <= '0;
            exception_q  <= 1'b0;
            exc_code_q   <= '0;
        end else if (en) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ptr_q        <= ptr_d;
            op_q         <= op_d;
            depth_q      <= depth_d;
            skip_phase_q <= skip_phase_d;
            out_data_q   <= out_data_d;
            exception_q  <= exception_d;
            exc_code_q   <= exc_code_d;
        end
    end

    assign bus.prog_addr = pc_q;
    assign bus.prog_ren  = prog_ren;
    assign bus.data_addr = ptr_q;
    assign bus.data_ren  = data_ren;
    assign bus.data_wen  = data_wen;
    assign bus.data_wval = data_wval;
    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = (state_q == StOut);
    assign halted        = (state_q == StHalt);
    assign exception     = exception_q;
    assign exc_code      = exc_code_q;
endmodule
